// File: rtl/addsub_serial_n.sv
// Digit-serial adder/subtractor: processes DIGIT bits per cycle, LSB digit first,
// with a valid/ready handshake on both sides and registered carry/overflow/zero flags.

module addsub_serial_n_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, ci};
endmodule

module addsub_serial_n #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 st, st_nxt;
  logic [WIDTH-1:0]       a, b;
  logic                   c;
  logic [CW-1:0]          cnt;
  logic                   a_msb, b_msb;
  logic [DIGIT-1:0]       dsum;
  logic                   dc;
  logic [WIDTH+DIGIT-1:0] s_wide;
  logic [WIDTH-1:0]       s_nxt;
  logic                   last;

  addsub_serial_n_digit #(.DIGIT(DIGIT)) u_dig (
    .a  (a[DIGIT-1:0]),
    .b  (b[DIGIT-1:0]),
    .ci (c),
    .s  (dsum),
    .co (dc)
  );

  // New digit enters s from the top; after NDIG steps the LSB digit sits at bit 0.
  assign s_wide = {dsum, s};
  assign s_nxt  = s_wide[WIDTH+DIGIT-1:DIGIT];
  assign last   = (cnt == CW'(NDIG - 1));

  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt    = st;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (st)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) st_nxt = RUN;
      end
      RUN:  if (last) st_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a     <= '0;
      b     <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      case (st)
        IDLE: if (in_valid) begin
          // Subtract is x + ~y + 1: invert B and seed the carry with m.
          a     <= x;
          b     <= y ^ {WIDTH{m}};
          c     <= m;
          cnt   <= '0;
          a_msb <= x[WIDTH-1];
          b_msb <= y[WIDTH-1] ^ m;
        end
        RUN: begin
          a   <= a >> DIGIT;
          b   <= b >> DIGIT;
          s   <= s_nxt;
          c   <= dc;
          cnt <= cnt + 1'b1;
          if (last) begin
            cout <= dc;
            zero <= (s_nxt == '0);
            ovf  <= (a_msb == b_msb) && (s_nxt[WIDTH-1] != a_msb);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_addsub_serial_n.sv
// Directed bench: three instances (DIGIT=4, 1, 16) share operands and reset;
// each gets its own handshake so latency is checked per digit size.

module tb_addsub_serial_n;
  localparam int W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [W-1:0]     x, y;
  logic             m;
  logic [2:0]       iv, ordy, ir, ov, co, of, zr;
  logic [2:0][W-1:0] so;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DG = (g == 0) ? 4 : (g == 1) ? 1 : 16;
    addsub_serial_n #(.WIDTH(W), .DIGIT(DG)) u_dut (
      .clk(clk), .rst(rst), .in_valid(iv[g]), .in_ready(ir[g]),
      .x(x), .y(y), .m(m), .out_valid(ov[g]), .out_ready(ordy[g]),
      .s(so[g]), .cout(co[g]), .ovf(of[g]), .zero(zr[g])
    );
  end

  typedef struct {
    logic [W-1:0] x, y;
    logic         m;
    logic [W-1:0] s;
    logic         cout, ovf, zero;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int k, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h want %h", name, k, act, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 4 : (k == 1) ? 16 : 1;
  endfunction

  // Offer an operand set and wait for the result; leaves the DUT in DONE.
  task automatic start_wait(input int k, input logic [W-1:0] xa, input logic [W-1:0] ya,
                            input logic ma, output int lat);
    @(negedge clk);
    chk("in_ready_idle", k, W'(ir[k]), W'(1));
    x = xa; y = ya; m = ma; iv[k] = 1'b1;
    @(posedge clk); #1;
    iv[k] = 1'b0;
    x = ~xa; y = ~ya; m = ~ma;   // must not disturb the running operation
    lat = 0;
    while (!ov[k] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain(input int k);
    @(negedge clk);
    ordy[k] = 1'b1;
    @(posedge clk); #1;
    ordy[k] = 1'b0;
    chk("out_valid_after_hs", k, W'(ov[k]), W'(0));
    chk("in_ready_after_hs", k, W'(ir[k]), W'(1));
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int lat;
    start_wait(k, v.x, v.y, v.m, lat);
    chk("latency", k, W'(lat), W'(lat_of(k)));
    chk("s", k, so[k], v.s);
    chk("cout", k, W'(co[k]), W'(v.cout));
    chk("ovf", k, W'(of[k]), W'(v.ovf));
    chk("zero", k, W'(zr[k]), W'(v.zero));
    chk("in_ready_done", k, W'(ir[k]), W'(0));
    drain(k);
  endtask

  task automatic check_all_zero(input string name, input int k);
    chk({name, "_ov"}, k, W'(ov[k]), W'(0));
    chk({name, "_ir"}, k, W'(ir[k]), W'(1));
    chk({name, "_s"}, k, so[k], W'(0));
    chk({name, "_flags"}, k, W'({co[k], of[k], zr[k]}), W'(0));
  endtask

  initial begin
    vec_t vt[7];
    int   lat;
    logic [W-1:0] s_hold;
    logic [2:0]   f_hold;

    vt[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0};
    vt[1] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vt[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vt[4] = '{16'hABCD, 16'hABCD, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vt[5] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vt[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};

    rst = 1'b1; iv = '0; ordy = '0; x = '0; y = '0; m = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) check_all_zero("reset", k);
    @(negedge clk); rst = 1'b0;

    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 7; i++) run_vec(k, vt[i]);

    // Back-pressure: result must hold while the input side is being wiggled.
    start_wait(0, 16'h1234, 16'h0FFF, 1'b0, lat);
    chk("stall_lat", 0, W'(lat), W'(4));
    s_hold = so[0]; f_hold = {co[0], of[0], zr[0]};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      iv[0] = c[0]; x = W'($urandom); y = W'($urandom); m = c[1];
      @(posedge clk); #1;
      chk("stall_ov", 0, W'(ov[0]), W'(1));
      chk("stall_ir", 0, W'(ir[0]), W'(0));
      chk("stall_s", 0, so[0], 16'h2233);
      chk("stall_flags", 0, W'({co[0], of[0], zr[0]}), W'(f_hold));
      chk("stall_s_stable", 0, so[0], s_hold);
    end
    iv[0] = 1'b0;
    drain(0);
    run_vec(0, '{16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0});

    // Abort in RUN at counter=2: no result may follow.
    @(negedge clk);
    x = 16'h7FFF; y = 16'h0001; m = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;              // accepted, counter=0
    iv[0] = 1'b0;
    repeat (2) @(posedge clk);       // counter=2
    #1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_all_zero("abort", 0);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk("abort_no_valid", 0, W'(ov[0]), W'(0));
    end
    run_vec(0, '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0});

    // Reset wins over in_valid on the same edge.
    @(negedge clk);
    x = 16'h0001; y = 16'h0001; iv[2] = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; iv[2] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("rst_prio_ov", 2, W'(ov[2]), W'(0));
      chk("rst_prio_ir", 2, W'(ir[2]), W'(1));
    end

    // Abort in DONE also discards the result.
    start_wait(2, 16'h0001, 16'h0002, 1'b0, lat);
    chk("done_abort_pre", 2, W'(ov[2]), W'(1));
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_all_zero("done_abort", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
